// File: rtl/apad_pkg.sv
// Shared types and sizing helpers for the analog pad mux arbiter.
package apad_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StActive,
    StRelease
  } apad_state_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

  // Counters are sized for the full legal range of DEAD_CYCLES and MAX_HOLD.
  localparam int unsigned DeadCntW = cnt_width(255);
  localparam int unsigned HoldCntW = cnt_width(65535);

endpackage

// File: rtl/apad_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i.
module apad_rr_pick
  import apad_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]              req_i,
  input  logic [idx_width(N_REQ)-1:0]   rr_ptr_i,
  output logic [idx_width(N_REQ)-1:0]   winner_o,
  output logic                          valid_o
);

  localparam int unsigned IdxW = idx_width(N_REQ);

  always_comb begin
    int unsigned slot;
    slot     = 0;
    valid_o  = 1'b0;
    winner_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      slot = 32'(rr_ptr_i) + i;
      if (slot >= N_REQ) slot = slot - N_REQ;
      if (!valid_o && req_i[IdxW'(slot)]) begin
        valid_o  = 1'b1;
        winner_o = IdxW'(slot);
      end
    end
  end

endmodule

// File: rtl/apad_mux_arbiter.sv
// Shares one analog pad between N_REQ requesters with round-robin arbitration,
// break-before-make dead time and a bounded hold under contention.
module apad_mux_arbiter
  import apad_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DEAD_CYCLES = 4,
  parameter int unsigned MAX_HOLD    = 64
) (
  input  logic                        Clock,
  input  logic                        nReset,
  input  logic [N_REQ-1:0]            req,
  output logic [N_REQ-1:0]            grant,
  output logic [N_REQ-1:0]            sw_en,
  output logic [idx_width(N_REQ)-1:0] owner,
  output logic                        busy
);

  localparam int unsigned IdxW = idx_width(N_REQ);
  localparam logic [DeadCntW-1:0] DeadLoad = DeadCntW'(DEAD_CYCLES - 1);
  localparam logic [HoldCntW-1:0] HoldLoad = HoldCntW'(MAX_HOLD - 1);

  apad_state_t         state_q;
  logic [IdxW-1:0]     owner_q;
  logic [IdxW-1:0]     rr_ptr_q;
  logic [IdxW-1:0]     rr_ptr_d;
  logic [DeadCntW-1:0] dead_q;
  logic [HoldCntW-1:0] hold_q;
  logic [N_REQ-1:0]    grant_q;
  logic                busy_q;

  logic [IdxW-1:0]     pick_idx;
  logic                pick_valid;
  logic [N_REQ-1:0]    owner_oh;
  logic                owner_req;
  logic                others_req;

  apad_rr_pick #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  assign owner_oh   = N_REQ'(1) << owner_q;
  assign owner_req  = req[owner_q];
  assign others_req = |(req & ~owner_oh);
  assign rr_ptr_d   = (pick_idx == IdxW'(N_REQ - 1)) ? '0 : pick_idx + IdxW'(1);

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      dead_q   <= '0;
      hold_q   <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            owner_q  <= pick_idx;
            rr_ptr_q <= rr_ptr_d;
            dead_q   <= DeadLoad;
            busy_q   <= 1'b1;
            state_q  <= StSettle;
          end
        end
        StSettle: begin
          if (!owner_req) begin
            dead_q  <= DeadLoad;
            state_q <= StRelease;
          end else if (dead_q == '0) begin
            hold_q  <= HoldLoad;
            grant_q <= owner_oh;
            state_q <= StActive;
          end else begin
            dead_q <= dead_q - DeadCntW'(1);
          end
        end
        StActive: begin
          // Hold budget only drains while someone else is waiting.
          if (!owner_req || (others_req && hold_q == '0)) begin
            grant_q <= '0;
            dead_q  <= DeadLoad;
            state_q <= StRelease;
          end else if (others_req) begin
            hold_q <= hold_q - HoldCntW'(1);
          end else begin
            hold_q <= HoldLoad;
          end
        end
        StRelease: begin
          if (dead_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            dead_q <= dead_q - DeadCntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant = grant_q;
  assign sw_en = grant_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_apad_mux_arbiter.sv
// Directed and random checks for apad_mux_arbiter (N_REQ=4, DEAD_CYCLES=4, MAX_HOLD=16).
module tb_apad_mux_arbiter;

  logic       Clock = 1'b0;
  logic       nReset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] sw_en;
  logic [1:0] owner;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic       mon_en = 1'b0;
  logic       mon_rst;
  logic [3:0] last_grant;
  logic       last_valid = 1'b0;
  int         zero_run = 0;

  apad_mux_arbiter #(
    .N_REQ       (4),
    .DEAD_CYCLES (4),
    .MAX_HOLD    (16)
  ) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .req    (req),
    .grant  (grant),
    .sw_en  (sw_en),
    .owner  (owner),
    .busy   (busy)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Invariants checked every cycle once out of the first reset.
  always @(posedge Clock) begin
    mon_rst = !nReset;
    #1;
    if (mon_en) begin
      total++;
      if (!$onehot0(sw_en)) begin
        bad++;
        $display("FAIL onehot0_sw_en: sw_en=%b required at most one bit", sw_en);
      end
      total++;
      if (sw_en !== grant) begin
        bad++;
        $display("FAIL sw_en_eq_grant: sw_en=%b required %b", sw_en, grant);
      end
      if (mon_rst) begin
        last_valid = 1'b0;
        zero_run   = 0;
      end else if (grant == 4'b0) begin
        zero_run++;
      end else begin
        if (last_valid && grant != last_grant) begin
          total++;
          if (zero_run < 9) begin
            bad++;
            $display("FAIL dead_time: gap=%0d cycles required >=9", zero_run);
          end
        end
        last_grant = grant;
        last_valid = 1'b1;
        zero_run   = 0;
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy);
    end
  endtask

  task automatic wait_grant(input string name, input logic [3:0] want);
    int n = 0;
    while (grant == 4'b0 && n < 60) begin
      step();
      n++;
    end
    total++;
    if (grant !== want) begin
      bad++;
      $display("FAIL %s_grant: grant=%b required %b", name, grant, want);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    req    = 4'b0;
    repeat (3) step();
    total++;
    if (grant !== 4'b0 || sw_en !== 4'b0) begin
      bad++;
      $display("FAIL reset_grant: grant=%b sw_en=%b required 0000", grant, sw_en);
    end
    total++;
    if (owner !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_owner_busy: owner=%0d busy=%b required 0/0", owner, busy);
    end
    nReset = 1'b1;
    mon_en = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [3:0] exp;
    req = 4'b0010;
    for (int c = 1; c <= 5; c++) begin
      step();
      exp = (c == 5) ? 4'b0010 : 4'b0000;
      total++;
      if (grant !== exp) begin
        bad++;
        $display("FAIL single_latency c=%0d: grant=%b required %b", c, grant, exp);
      end
      if (c == 1) begin
        total++;
        if (owner !== 2'd1 || busy !== 1'b1) begin
          bad++;
          $display("FAIL single_owner: owner=%0d busy=%b required 1/1", owner, busy);
        end
      end
    end
    repeat (10) step();
    req = 4'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      total++;
      if (grant !== 4'b0 || busy !== (c <= 4)) begin
        bad++;
        $display("FAIL single_release c=%0d: grant=%b busy=%b required 0000/%b",
                 c, grant, busy, (c <= 4));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] order [3];
    int zero;
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b1000;
    nReset = 1'b0;
    step();
    nReset = 1'b1;
    req    = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      zero = 0;
      do begin
        step();
        if (grant == 4'b0) zero++;
      end while (grant == 4'b0 && zero < 40);
      total++;
      if (grant !== order[k]) begin
        bad++;
        $display("FAIL simul_order k=%0d: grant=%b required %b", k, grant, order[k]);
      end
      if (k > 0) begin
        total++;
        if (zero != 9) begin
          bad++;
          $display("FAIL simul_gap k=%0d: gap=%0d required 9", k, zero);
        end
      end
      repeat (5) step();
      req = req & ~order[k];
    end
    wait_idle("simul");
  endtask

  task automatic test_preempt();
    logic [3:0] exp;
    req = 4'b0001;
    wait_grant("preempt_first", 4'b0001);
    repeat (3) step();
    req = 4'b0101;
    for (int c = 1; c <= 16; c++) begin
      step();
      exp = (c < 16) ? 4'b0001 : 4'b0000;
      total++;
      if (grant !== exp) begin
        bad++;
        $display("FAIL preempt_hold c=%0d: grant=%b required %b", c, grant, exp);
      end
    end
    for (int c = 1; c <= 9; c++) begin
      step();
      exp = (c < 9) ? 4'b0000 : 4'b0100;
      total++;
      if (grant !== exp) begin
        bad++;
        $display("FAIL preempt_handover c=%0d: grant=%b required %b", c, grant, exp);
      end
    end
    total++;
    if (owner !== 2'd2) begin
      bad++;
      $display("FAIL preempt_owner: owner=%0d required 2", owner);
    end
    repeat (3) step();
    req = 4'b0001;
    for (int c = 1; c <= 10; c++) begin
      step();
      exp = (c < 10) ? 4'b0000 : 4'b0001;
      total++;
      if (grant !== exp) begin
        bad++;
        $display("FAIL preempt_regrant c=%0d: grant=%b required %b", c, grant, exp);
      end
    end
    req = 4'b0;
    wait_idle("preempt");
  endtask

  task automatic test_abort();
    req = 4'b0010;
    for (int c = 1; c <= 7; c++) begin
      step();
      total++;
      if (sw_en !== 4'b0 || busy !== (c <= 6)) begin
        bad++;
        $display("FAIL abort c=%0d: sw_en=%b busy=%b required 0000/%b",
                 c, sw_en, busy, (c <= 6));
      end
      if (c == 1) begin
        total++;
        if (owner !== 2'd1) begin
          bad++;
          $display("FAIL abort_owner: owner=%0d required 1", owner);
        end
      end
      if (c == 2) req = 4'b0;
    end
  endtask

  task automatic test_reset_active();
    logic [3:0] exp;
    req = 4'b0100;
    wait_grant("rstact_first", 4'b0100);
    repeat (2) step();
    nReset = 1'b0;
    step();
    total++;
    if (grant !== 4'b0 || sw_en !== 4'b0 || owner !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstact_clear: grant=%b sw_en=%b owner=%0d busy=%b required all 0",
               grant, sw_en, owner, busy);
    end
    nReset = 1'b1;
    req    = 4'b1100;
    for (int c = 1; c <= 5; c++) begin
      step();
      exp = (c == 5) ? 4'b0100 : 4'b0000;
      total++;
      if (grant !== exp) begin
        bad++;
        $display("FAIL rstact_regrant c=%0d: grant=%b required %b", c, grant, exp);
      end
      if (c == 1) begin
        total++;
        if (owner !== 2'd2) begin
          bad++;
          $display("FAIL rstact_owner: owner=%0d required 2", owner);
        end
      end
    end
    req = 4'b0;
    wait_idle("rstact");
  endtask

  task automatic test_random();
    int cyc = 0;
    int len;
    while (cyc < 10000) begin
      req = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 30);
      repeat (len) step();
      cyc += len;
    end
    req = 4'b0;
    wait_idle("random");
    total++;
    if (grant !== 4'b0) begin
      bad++;
      $display("FAIL random_final: grant=%b required 0000", grant);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_preempt();
    test_abort();
    test_reset_active();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
